// File: rtl/axi4_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_splitter
// Purpose  : Splits AXI4 INCR bursts at 4 KiB page boundaries; passes FIXED/WRAP
//            through; drops illegal requests with a one-cycle error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_splitter #(
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADDR_WIDTH-1:0] in_addr_i,
    input  logic [1:0]            in_burst_i,
    input  logic [7:0]            in_len_i,
    input  logic [2:0]            in_size_i,
    input  logic [ID_WIDTH-1:0]   in_id_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [1:0]            out_burst_o,
    output logic [7:0]            out_len_o,
    output logic [2:0]            out_size_o,
    output logic [ID_WIDTH-1:0]   out_id_o,
    output logic                  out_first_o,
    output logic                  out_last_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam logic [1:0] c_burst_incr = 2'd1;
    localparam logic [1:0] c_burst_wrap = 2'd2;
    localparam logic [1:0] c_burst_rsvd = 2'd3;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [1:0]            r_burst;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [ID_WIDTH-1:0]   r_id;
    logic [8:0]            r_rem;
    logic                  r_first;

    logic                  w_accept;
    logic                  w_valid;
    logic [ADDR_WIDTH-1:0] w_align_mask;
    logic                  w_wrap_len_ok;
    logic                  w_illegal;
    logic [12:0]           w_size_mask;
    logic [12:0]           w_off;
    logic [12:0]           w_avail;
    logic [12:0]           w_rem13;
    logic                  w_rem_fits;
    logic [12:0]           w_n;
    logic                  w_incr;
    logic [7:0]            w_sub_len;
    logic                  w_sub_last;
    logic [ADDR_WIDTH-13:0] w_page_next;

    assign w_valid    = (r_state == S_ISSUE);
    assign in_ready_o = (r_state == S_IDLE) && !rst_i;
    assign w_accept   = in_valid_i && in_ready_o;

    // Request legality is judged on the raw inputs in the acceptance cycle
    assign w_align_mask  = (ADDR_WIDTH'(1) << in_size_i) - ADDR_WIDTH'(1);
    assign w_wrap_len_ok = (in_len_i == 8'd1) || (in_len_i == 8'd3) ||
                           (in_len_i == 8'd7) || (in_len_i == 8'd15);
    assign w_illegal     = (in_burst_i == c_burst_rsvd) ||
                           ((in_burst_i == c_burst_wrap) &&
                            (!w_wrap_len_ok || ((in_addr_i & w_align_mask) != '0)));

    // Beats left before the current 4 KiB page ends, counted from the aligned address
    assign w_size_mask = (13'd1 << r_size) - 13'd1;
    assign w_off       = {1'b0, r_cur[11:0]} & ~w_size_mask;
    assign w_avail     = (13'd4096 - w_off) >> r_size;
    assign w_rem13     = {4'd0, r_rem};
    assign w_rem_fits  = (w_rem13 <= w_avail);
    assign w_n         = w_rem_fits ? w_rem13 : w_avail;
    assign w_incr      = (r_burst == c_burst_incr);
    assign w_sub_len   = w_incr ? 8'(w_n - 13'd1) : r_len;
    assign w_sub_last  = w_incr ? w_rem_fits : 1'b1;
    assign w_page_next = r_cur[ADDR_WIDTH-1:12] + {{(ADDR_WIDTH-13){1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_illegal ? S_ERR : S_ISSUE;
            S_ISSUE: if (out_ready_i && w_sub_last) w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cur   <= '0;
            r_burst <= 2'd0;
            r_len   <= 8'd0;
            r_size  <= 3'd0;
            r_id    <= '0;
            r_rem   <= 9'd0;
            r_first <= 1'b0;
        end else if (w_accept) begin
            r_cur   <= in_addr_i;
            r_burst <= in_burst_i;
            r_len   <= in_len_i;
            r_size  <= in_size_i;
            r_id    <= in_id_i;
            r_rem   <= {1'b0, in_len_i} + 9'd1;
            r_first <= 1'b1;
        end else if (w_valid && out_ready_i && !w_sub_last) begin
            r_cur   <= {w_page_next, 12'h000};
            r_rem   <= r_rem - w_n[8:0];
            r_first <= 1'b0;
        end
    end

    // Outputs are forced to zero whenever no sub-burst is being presented
    assign out_valid_o = w_valid;
    assign out_addr_o  = w_valid ? r_cur   : '0;
    assign out_burst_o = w_valid ? r_burst : 2'd0;
    assign out_len_o   = w_valid ? w_sub_len : 8'd0;
    assign out_size_o  = w_valid ? r_size  : 3'd0;
    assign out_id_o    = w_valid ? r_id    : '0;
    assign out_first_o = w_valid && r_first;
    assign out_last_o  = w_valid && w_sub_last;
    assign err_o       = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_burst_splitter
// Purpose  : Table-driven scoreboard bench for axi4_burst_splitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_splitter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] in_addr_i;
    logic [1:0]  in_burst_i;
    logic [7:0]  in_len_i;
    logic [2:0]  in_size_i;
    logic [3:0]  in_id_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_addr_o;
    logic [1:0]  out_burst_o;
    logic [7:0]  out_len_o;
    logic [2:0]  out_size_o;
    logic [3:0]  out_id_o;
    logic        out_first_o;
    logic        out_last_o;
    logic        err_o;

    axi4_burst_splitter #(.ADDR_WIDTH(64), .ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
        .in_burst_i(in_burst_i), .in_len_i(in_len_i), .in_size_i(in_size_i), .in_id_i(in_id_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_addr_o(out_addr_o),
        .out_burst_o(out_burst_o), .out_len_o(out_len_o), .out_size_o(out_size_o),
        .out_id_o(out_id_o), .out_first_o(out_first_o), .out_last_o(out_last_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  burst;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [3:0]  id;
        bit          exp_err;
        int          exp_nsub;
    } req_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic        first;
        logic        last;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [3:0]  id;
    } sub_t;

    sub_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hs_count = 0;
    bit   hs_seen  = 0;
    bit   stall    = 0;
    int   stall_cnt = 0;
    req_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic req_t mk(input logic [63:0] a, input logic [1:0] b, input logic [7:0] l,
                                input logic [2:0] s, input logic [3:0] id, input bit e, input int n);
        req_t r;
        r.addr = a; r.burst = b; r.len = l; r.size = s; r.id = id; r.exp_err = e; r.exp_nsub = n;
        return r;
    endfunction

    // Reference model: walks every beat address and groups consecutive beats by page
    function automatic longint unsigned beat_addr(input longint unsigned a, input longint unsigned sz,
                                                  input int k);
        if (k == 0) return a;
        return (a & ~(sz - 1)) + longint'(k) * sz;
    endfunction

    function automatic void push_model(input req_t r);
        sub_t e;
        longint unsigned sz;
        int beats, k, j;
        e.burst = r.burst; e.size = r.size; e.id = r.id;
        if (r.burst != 2'd1) begin
            e.addr = r.addr; e.len = r.len; e.first = 1'b1; e.last = 1'b1;
            q.push_back(e);
            return;
        end
        sz = 64'd1 << r.size;
        beats = int'(r.len) + 1;
        k = 0;
        while (k < beats) begin
            j = 1;
            while ((k + j < beats) &&
                   ((beat_addr(r.addr, sz, k + j) >> 12) == (beat_addr(r.addr, sz, k) >> 12)))
                j++;
            e.addr  = beat_addr(r.addr, sz, k);
            e.len   = 8'(j - 1);
            e.first = (k == 0);
            e.last  = (k + j == beats);
            q.push_back(e);
            k += j;
        end
    endfunction

    // Scoreboard monitor: every presented sub-burst must match the queue head
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (out_valid_o) begin
                if (q.size() == 0) chk("unexpected_sub", {63'd0, out_valid_o}, 64'd0);
                else begin
                    chk("sub_addr", out_addr_o, q[0].addr);
                    chk("sub_len", {56'd0, out_len_o}, {56'd0, q[0].len});
                    chk("sub_flags", {53'd0, out_first_o, out_last_o, out_burst_o, out_size_o, out_id_o},
                        {53'd0, q[0].first, q[0].last, q[0].burst, q[0].size, q[0].id});
                    if (out_ready_i) begin
                        void'(q.pop_front());
                        hs_count++;
                        hs_seen = 1'b1;
                    end
                end
            end
            if (err_o) chk("err_with_valid", {63'd0, out_valid_o}, 64'd0);
        end
    end

    // Sink: optionally withholds ready for 3 cycles per sub-burst
    initial begin
        out_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (hs_seen) begin
                stall_cnt = 0;
                hs_seen = 1'b0;
            end
            if (stall && out_valid_o && stall_cnt < 3) begin
                out_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                out_ready_i = 1'b1;
            end
        end
    end

    task automatic issue(input req_t r);
        int cyc;
        if (!r.exp_err) push_model(r);
        @(posedge clk_i);
        #1;
        in_addr_i = r.addr; in_burst_i = r.burst; in_len_i = r.len;
        in_size_i = r.size; in_id_i = r.id; in_valid_i = 1'b1;
        cyc = 0;
        @(negedge clk_i);
        while (!in_ready_o) begin
            cyc++;
            if (cyc > 50) begin
                chk("accept_timeout", {63'd0, in_ready_o}, 64'd1);
                in_valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!(q.size() == 0 && in_ready_o)) begin
            @(negedge clk_i);
            cyc++;
            if (cyc > 400) begin
                chk("done_timeout", 64'(q.size()), 64'd0);
                break;
            end
        end
    endtask

    task automatic run_req(input req_t r);
        int start;
        start = hs_count;
        issue(r);
        if (r.exp_err) begin
            @(negedge clk_i);
            chk("err_pulse", {63'd0, err_o}, 64'd1);
            chk("err_no_valid", {63'd0, out_valid_o}, 64'd0);
            @(negedge clk_i);
            chk("err_one_cycle", {63'd0, err_o}, 64'd0);
            chk("ready_after_err", {63'd0, in_ready_o}, 64'd1);
        end else begin
            wait_done();
            chk("nsub", 64'(hs_count - start), 64'(r.exp_nsub));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, cyc;
        tbl[0] = mk(64'h1000, 2'd1, 8'd15, 3'd3, 4'h1, 1'b0, 1);
        tbl[1] = mk(64'h0FF0, 2'd1, 8'd7, 3'd3, 4'h2, 1'b0, 2);
        tbl[2] = mk(64'h0FFC, 2'd1, 8'd255, 3'd7, 4'h3, 1'b0, 9);
        tbl[3] = mk(64'h0FF8, 2'd0, 8'd15, 3'd3, 4'h4, 1'b0, 1);
        tbl[4] = mk(64'h0FF0, 2'd2, 8'd3, 3'd2, 4'h5, 1'b0, 1);
        tbl[5] = mk(64'h0100, 2'd2, 8'd5, 3'd2, 4'h6, 1'b1, 0);
        tbl[6] = mk(64'h0200, 2'd3, 8'd3, 3'd2, 4'h7, 1'b1, 0);
        tbl[7] = mk(64'h0002, 2'd2, 8'd3, 3'd2, 4'h8, 1'b1, 0);
        tbl[8] = mk(64'hFFFF_FFFF_FFFF_FFF0, 2'd1, 8'd3, 3'd3, 4'h9, 1'b0, 2);
        tbl[9] = mk(64'h1FFF, 2'd1, 8'd1, 3'd0, 4'hA, 1'b0, 2);

        rst_i = 1'b1; in_valid_i = 1'b0;
        in_addr_i = '0; in_burst_i = '0; in_len_i = '0; in_size_i = '0; in_id_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_in_ready", {63'd0, in_ready_o}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        chk("rst_fields", {out_first_o, out_last_o, out_burst_o, out_len_o, out_size_o, out_id_o, 44'd0}
            | out_addr_o, 64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_rst", {63'd0, in_ready_o}, 64'd1);

        for (int i = 0; i < 10; i++) run_req(tbl[i]);

        // Backpressure: same split must come out unchanged and stable while stalled
        stall = 1'b1;
        run_req(tbl[1]);
        stall = 1'b0;

        // Reset in the middle of the 9-way split
        start = hs_count;
        issue(tbl[2]);
        cyc = 0;
        while (hs_count == start && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("first_hs_seen", 64'(hs_count - start), 64'd1);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        q.delete();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("midrst_ready", {63'd0, in_ready_o}, 64'd1);
        repeat (5) begin
            @(negedge clk_i);
            chk("midrst_no_resume", {63'd0, out_valid_o}, 64'd0);
        end
        run_req(tbl[0]);
        run_req(tbl[9]);

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
